// File: rtl/wb_stage.sv
// Write-back stage: retires MEM results into the register file, sequences CSR
// read-modify-write, raises traps. WB_INSTRET_EN enables the retired-instruction counter.
module wb_stage #(
  parameter int INSTRET_W = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_in,
  output logic                 ready_out,
  input  logic                 flush_in,
  input  logic [31:0]          PC_MEM,
  input  logic [31:0]          rd_data_MEM,
  input  logic [31:0]          csr_wdata_MEM,
  input  logic [31:0]          exc_cause_MEM,
  input  logic                 rd_wena_MEM,
  input  logic                 csr_rena_MEM,
  input  logic                 csr_wena_MEM,
  input  logic                 trap_ret_MEM,
  input  logic                 exc_pend_MEM,
  input  logic [5:0]           rd_addr_MEM,
  input  logic [11:0]          csr_addr_MEM,
  input  logic [1:0]           csr_op_MEM,
  input  logic [4:0]           fpu_flags_MEM,
  output logic                 rf_wena,
  output logic [5:0]           rf_addr,
  output logic [31:0]          rf_data,
  output logic                 csr_rena,
  output logic                 csr_wena,
  output logic [11:0]          csr_addr,
  output logic [31:0]          csr_wdata,
  input  logic [31:0]          csr_rdata,
  output logic                 fflags_wena,
  output logic [4:0]           fflags_set,
  output logic                 exc_req,
  output logic [31:0]          exc_pc,
  output logic [31:0]          exc_cause,
  output logic                 trap_ret,
  input  logic                 exc_taken_csr,
  output logic [INSTRET_W-1:0] instret
);

  // state  | meaning
  // IDLE   | accepting from MEM; non-CSR ops retire combinationally
  // CSR_RD | reading the addressed CSR into old_q
  // CSR_WR | writing the modified CSR value, old value to rd, retire
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] CSR_RD = 2'd1;
  localparam logic [1:0] CSR_WR = 2'd2;

  localparam logic [1:0] CSR_RW = 2'd1;
  localparam logic [1:0] CSR_RS = 2'd2;
  localparam logic [1:0] CSR_RC = 2'd3;

  logic [1:0]  state;
  logic [31:0] old_q;

  // Only the fields used by the CSR_RD/CSR_WR cycles are kept.
  logic        lat_rd_wena;
  logic        lat_csr_rena;
  logic        lat_csr_wena;
  logic [5:0]  lat_rd_addr;
  logic [11:0] lat_csr_addr;
  logic [1:0]  lat_csr_op;
  logic [31:0] lat_csr_wdata;

  logic        accept;
  logic        is_csr;
  logic        retire;
  logic [31:0] csr_new;

  assign is_csr = csr_rena_MEM || csr_wena_MEM;

  always_comb begin
    case (lat_csr_op)
      CSR_RW:  csr_new = lat_csr_wdata;
      CSR_RS:  csr_new = old_q | lat_csr_wdata;
      CSR_RC:  csr_new = old_q & ~lat_csr_wdata;
      default: csr_new = lat_csr_wdata;
    endcase
  end

  always_comb begin
    ready_out   = reset && (state == IDLE) && !exc_taken_csr;
    accept      = valid_in && ready_out;
    rf_wena     = 1'b0;
    rf_addr     = 6'd0;
    rf_data     = 32'd0;
    csr_rena    = 1'b0;
    csr_wena    = 1'b0;
    csr_addr    = 12'd0;
    csr_wdata   = 32'd0;
    fflags_wena = 1'b0;
    fflags_set  = 5'd0;
    exc_req     = 1'b0;
    exc_pc      = 32'd0;
    exc_cause   = 32'd0;
    trap_ret    = 1'b0;
    retire      = 1'b0;
    if (reset) begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (exc_pend_MEM) begin
              exc_req   = 1'b1;
              exc_pc    = PC_MEM;
              exc_cause = exc_cause_MEM;
            end else begin
              trap_ret = trap_ret_MEM;
              if (fpu_flags_MEM != 5'd0) begin
                fflags_wena = 1'b1;
                fflags_set  = fpu_flags_MEM;
              end
              if (!is_csr) begin
                retire = 1'b1;
                if (rd_wena_MEM && (rd_addr_MEM != 6'd0)) begin
                  rf_wena = 1'b1;
                  rf_addr = rd_addr_MEM;
                  rf_data = rd_data_MEM;
                end
              end
            end
          end
        end
        CSR_RD: begin
          csr_rena = lat_csr_rena;
          csr_addr = lat_csr_addr;
        end
        CSR_WR: begin
          csr_addr = lat_csr_addr;
          retire   = 1'b1;
          if (lat_csr_wena) begin
            csr_wena  = 1'b1;
            csr_wdata = csr_new;
          end
          if (lat_rd_wena && (lat_rd_addr != 6'd0)) begin
            rf_wena = 1'b1;
            rf_addr = lat_rd_addr;
            rf_data = old_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      old_q         <= 32'd0;
      lat_rd_wena   <= 1'b0;
      lat_csr_rena  <= 1'b0;
      lat_csr_wena  <= 1'b0;
      lat_rd_addr   <= 6'd0;
      lat_csr_addr  <= 12'd0;
      lat_csr_op    <= 2'd0;
      lat_csr_wdata <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && !exc_pend_MEM && is_csr) begin
            lat_rd_wena   <= rd_wena_MEM;
            lat_csr_rena  <= csr_rena_MEM;
            lat_csr_wena  <= csr_wena_MEM;
            lat_rd_addr   <= rd_addr_MEM;
            lat_csr_addr  <= csr_addr_MEM;
            lat_csr_op    <= csr_op_MEM;
            lat_csr_wdata <= csr_wdata_MEM;
            if (!flush_in) state <= CSR_RD;
          end
        end
        CSR_RD: begin
          if (flush_in) begin
            state <= IDLE;
          end else begin
            old_q <= csr_rdata;
            state <= CSR_WR;
          end
        end
        CSR_WR:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WB_INSTRET_EN
  logic [INSTRET_W-1:0] instret_q;

  always_ff @(posedge clk) begin
    if (!reset)      instret_q <= '0;
    else if (retire) instret_q <= instret_q + 1'b1;
  end

  assign instret = instret_q;
`else
  logic unused_retire;
  assign unused_retire = retire;
  assign instret       = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: expected writes/traps are queued at stimulus
// time and popped by a negedge monitor when the DUT asserts the matching enable.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in, ready_out, flush_in;
  logic [31:0] PC_MEM, rd_data_MEM, csr_wdata_MEM, exc_cause_MEM;
  logic        rd_wena_MEM, csr_rena_MEM, csr_wena_MEM, trap_ret_MEM, exc_pend_MEM;
  logic [5:0]  rd_addr_MEM;
  logic [11:0] csr_addr_MEM;
  logic [1:0]  csr_op_MEM;
  logic [4:0]  fpu_flags_MEM;
  logic        rf_wena;
  logic [5:0]  rf_addr;
  logic [31:0] rf_data;
  logic        csr_rena, csr_wena;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, csr_rdata;
  logic        fflags_wena;
  logic [4:0]  fflags_set;
  logic        exc_req;
  logic [31:0] exc_pc, exc_cause;
  logic        trap_ret, exc_taken_csr;
  logic [63:0] instret;

  wb_stage #(.INSTRET_W(64)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_out(ready_out), .flush_in(flush_in),
    .PC_MEM(PC_MEM), .rd_data_MEM(rd_data_MEM), .csr_wdata_MEM(csr_wdata_MEM),
    .exc_cause_MEM(exc_cause_MEM), .rd_wena_MEM(rd_wena_MEM), .csr_rena_MEM(csr_rena_MEM),
    .csr_wena_MEM(csr_wena_MEM), .trap_ret_MEM(trap_ret_MEM), .exc_pend_MEM(exc_pend_MEM),
    .rd_addr_MEM(rd_addr_MEM), .csr_addr_MEM(csr_addr_MEM), .csr_op_MEM(csr_op_MEM),
    .fpu_flags_MEM(fpu_flags_MEM), .rf_wena(rf_wena), .rf_addr(rf_addr), .rf_data(rf_data),
    .csr_rena(csr_rena), .csr_wena(csr_wena), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .fflags_wena(fflags_wena), .fflags_set(fflags_set),
    .exc_req(exc_req), .exc_pc(exc_pc), .exc_cause(exc_cause), .trap_ret(trap_ret),
    .exc_taken_csr(exc_taken_csr), .instret(instret)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] EV_RF = 2'd0, EV_CSR = 2'd1, EV_EXC = 2'd2, EV_FF = 2'd3;
  typedef struct {
    logic [1:0]  kind;
    logic [31:0] a;
    logic [31:0] d;
  } ev_t;

  ev_t         sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] exp_ir  = 64'd0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic expect_ev(input logic [1:0] kind, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    e.kind = kind; e.a = a; e.d = d;
    sb_q.push_back(e);
  endtask

  task automatic observe(input logic [1:0] kind, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    chk("sb_has_entry", {63'd0, sb_q.size() != 0}, 64'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk("ev_kind", {62'd0, kind}, {62'd0, e.kind});
      chk("ev_addr", {32'd0, a}, {32'd0, e.a});
      chk("ev_data", {32'd0, d}, {32'd0, e.d});
    end
  endtask

  always @(negedge clk) begin
    if (exc_req)     observe(EV_EXC, exc_pc, exc_cause);
    if (fflags_wena) observe(EV_FF, 32'd0, {27'd0, fflags_set});
    if (csr_wena)    observe(EV_CSR, {20'd0, csr_addr}, csr_wdata);
    if (rf_wena)     observe(EV_RF, {26'd0, rf_addr}, rf_data);
  end

  task automatic retire_model();
`ifdef WB_INSTRET_EN
    exp_ir = exp_ir + 64'd1;
`endif
  endtask

  task automatic clr_in();
    valid_in = 0; PC_MEM = 0; rd_data_MEM = 0; csr_wdata_MEM = 0; exc_cause_MEM = 0;
    rd_wena_MEM = 0; csr_rena_MEM = 0; csr_wena_MEM = 0; trap_ret_MEM = 0; exc_pend_MEM = 0;
    rd_addr_MEM = 0; csr_addr_MEM = 0; csr_op_MEM = 0; fpu_flags_MEM = 0;
  endtask

  // One-cycle ALU-style instruction, accepted at the next rising edge.
  task automatic alu_op(input logic [5:0] rd, input logic [31:0] data, input logic wena,
                        input logic [4:0] ff, input logic tret);
    @(posedge clk); #1;
    clr_in();
    valid_in = 1; rd_addr_MEM = rd; rd_data_MEM = data; rd_wena_MEM = wena;
    fpu_flags_MEM = ff; trap_ret_MEM = tret;
    if (ff != 0) expect_ev(EV_FF, 32'd0, {27'd0, ff});
    if (wena && rd != 0) expect_ev(EV_RF, {26'd0, rd}, data);
    @(negedge clk);
    chk("trap_ret", {63'd0, trap_ret}, {63'd0, tret});
    @(posedge clk); #1;
    clr_in();
    retire_model();
  endtask

  // Drives a CSR instruction for its accept cycle only; leaves the bench just after that edge.
  task automatic csr_issue(input logic [1:0] op, input logic [11:0] ca, input logic [31:0] wd,
                           input logic [5:0] rd);
    @(posedge clk); #1;
    clr_in();
    valid_in = 1; csr_rena_MEM = 1; csr_wena_MEM = 1; csr_op_MEM = op;
    csr_addr_MEM = ca; csr_wdata_MEM = wd; rd_addr_MEM = rd; rd_wena_MEM = 1;
    @(posedge clk); #1;
    clr_in();
  endtask

  function automatic logic [31:0] csr_model(input logic [1:0] op, input logic [31:0] o,
                                            input logic [31:0] w);
    case (op)
      2'd2:    return o | w;
      2'd3:    return o & ~w;
      default: return w;
    endcase
  endfunction

  task automatic csr_full(input logic [1:0] op, input logic [11:0] ca, input logic [31:0] wd,
                          input logic [5:0] rd, input logic [31:0] rdata);
    csr_rdata = rdata;
    expect_ev(EV_CSR, {20'd0, ca}, csr_model(op, rdata, wd));
    if (rd != 0) expect_ev(EV_RF, {26'd0, rd}, rdata);
    csr_issue(op, ca, wd, rd);
    @(negedge clk);
    chk("csr_rd_ready", {63'd0, ready_out}, 64'd0);
    @(negedge clk);
    chk("csr_wr_ready", {63'd0, ready_out}, 64'd0);
    @(posedge clk); #1;
    retire_model();
    @(negedge clk);
    chk("csr_done_ready", {63'd0, ready_out}, 64'd1);
  endtask

  initial begin
    clr_in();
    reset = 0; flush_in = 0; exc_taken_csr = 0; csr_rdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {63'd0, ready_out}, 64'd0);
    chk("rst_rf_wena", {63'd0, rf_wena}, 64'd0);
    chk("rst_instret", instret, 64'd0);
    @(posedge clk); #1;
    reset = 1;

    alu_op(6'd5, 32'h1234, 1'b1, 5'd0, 1'b0);
    @(negedge clk);
    chk("alu_instret", instret, exp_ir);

    csr_full(2'd2, 12'h300, 32'h3, 6'd7, 32'h8);
    chk("csrrs_instret", instret, exp_ir);
    for (int i = 0; i < 6; i++)
      csr_full(2'(1 + (i % 3)), 12'($urandom_range(0, 4095)), $urandom, 6'($urandom_range(1, 63)), $urandom);

    // Exception: single-cycle request, nothing retired.
    @(posedge clk); #1;
    clr_in();
    valid_in = 1; exc_pend_MEM = 1; PC_MEM = 32'h100; exc_cause_MEM = 32'h5;
    rd_wena_MEM = 1; rd_addr_MEM = 6'd9; fpu_flags_MEM = 5'h1;
    expect_ev(EV_EXC, 32'h100, 32'h5);
    @(posedge clk); #1;
    clr_in();
    @(negedge clk);
    chk("exc_instret", instret, exp_ir);

    alu_op(6'd0, 32'hFFFF, 1'b1, 5'd0, 1'b0);
    alu_op(6'd32, 32'hABCD, 1'b1, 5'd0, 1'b0);
    alu_op(6'd3, 32'h77, 1'b1, 5'h3, 1'b1);
    alu_op(6'd4, 32'h0, 1'b0, 5'd0, 1'b1);

    // exc_taken_csr blocks acceptance.
    @(posedge clk); #1;
    clr_in();
    exc_taken_csr = 1; valid_in = 1; rd_wena_MEM = 1; rd_addr_MEM = 6'd6; rd_data_MEM = 32'h55;
    @(negedge clk);
    chk("exc_taken_ready", {63'd0, ready_out}, 64'd0);
    @(posedge clk); #1;
    clr_in(); exc_taken_csr = 0;
    @(negedge clk);
    chk("exc_taken_instret", instret, exp_ir);

    // Flush during CSR_RD: no write, back to IDLE.
    csr_rdata = 32'hF0;
    csr_issue(2'd1, 12'h305, 32'h1, 6'd8);
    flush_in = 1;
    @(posedge clk); #1;
    flush_in = 0;
    @(negedge clk);
    chk("flush_ready", {63'd0, ready_out}, 64'd1);
    chk("flush_instret", instret, exp_ir);

    // Flush during CSR_WR: the write still completes.
    csr_rdata = 32'h10;
    expect_ev(EV_CSR, 32'h340, 32'h11);
    expect_ev(EV_RF, 32'd10, 32'h10);
    csr_issue(2'd2, 12'h340, 32'h1, 6'd10);
    @(posedge clk); #1;
    flush_in = 1;
    @(posedge clk); #1;
    flush_in = 0;
    retire_model();
    @(negedge clk);
    chk("flush_wr_ready", {63'd0, ready_out}, 64'd1);

    // Reset during CSR_WR: abandoned, counter cleared.
    csr_issue(2'd1, 12'h341, 32'h9, 6'd11);
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk("rst_wr_csr_wena", {63'd0, csr_wena}, 64'd0);
    @(posedge clk); #1;
    reset = 1;
    exp_ir = 64'd0;
    @(negedge clk);
    chk("rst_wr_instret", instret, 64'd0);
    chk("rst_wr_ready", {63'd0, ready_out}, 64'd1);

    for (int i = 0; i < 20; i++)
      alu_op(6'($urandom_range(0, 63)), $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 1'b0);
    @(negedge clk);
    chk("rand_instret", instret, exp_ir);

`ifdef WB_INSTRET_EN
    @(posedge clk); #1;
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_q;
    alu_op(6'd1, 32'h1, 1'b1, 5'd0, 1'b0);
    @(negedge clk);
    chk("instret_wrap", instret, 64'd0);
`endif

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("sb_empty", {32'd0, 32'(sb_q.size())}, 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter: INSTRET_W, 64, width of the retired-instruction counter.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  reset is synchronous and active-low (0 = reset, sampled on rising clk).
REQ-004 valid_in / ready_out / flush_in  in/out/in  1 each  handshake and flush from the MEM stage.
REQ-005 PC_MEM, rd_data_MEM, csr_wdata_MEM, exc_cause_MEM  in  32 each  MEM/WB register contents.
REQ-006 rd_wena_MEM, csr_rena_MEM, csr_wena_MEM, trap_ret_MEM, exc_pend_MEM  in  1 each  MEM/WB control flags.
REQ-007 rd_addr_MEM 6, csr_addr_MEM 12, csr_op_MEM 2, fpu_flags_MEM 5  in  destination register (bit 5 = FP file), CSR address, CSR op, FPU exception flags.
REQ-008 rf_wena / rf_addr / rf_data  out  1/6/32  register-file write port.
REQ-009 csr_rena / csr_wena / csr_addr / csr_wdata  out  1/1/12/32  CSR-file access port; csr_rdata  in  32.
REQ-010 fflags_wena / fflags_set  out  1/5  OR-accumulate into fflags.
REQ-011 exc_req / exc_pc / exc_cause / trap_ret  out  1/32/32/1  trap request to the CSR unit; exc_taken_csr  in  1.
REQ-012 instret  out  INSTRET_W  retired-instruction count.

Function
REQ-013 Transfer from MEM occurs when valid_in && ready_out; ready_out = (state == IDLE) && !exc_taken_csr.
REQ-014 FSM states IDLE, CSR_RD, CSR_WR; reset and flush_in force IDLE.
REQ-015 IDLE, accepted instruction without CSR access and without exc_pend: rf_wena = rd_wena_MEM, rf_addr/rf_data from MEM, in the same cycle (combinational, zero latency); retire.
REQ-016 Accepted instruction with csr_rena_MEM or csr_wena_MEM: latch all MEM fields; next state CSR_RD; no rf write in IDLE cycle.
REQ-017 CSR_RD (1 cycle): csr_rena = latched csr_rena; capture csr_rdata into old_q; next CSR_WR.
REQ-018 CSR_WR (1 cycle): csr_wena = latched csr_wena; csr_wdata = CSR_RW: wdata, CSR_RS: old_q | wdata, CSR_RC: old_q & ~wdata; rf write of old_q when rd_wena; retire; next IDLE.
REQ-019 CSR instruction thus occupies 3 cycles; ready_out low in CSR_RD and CSR_WR.
REQ-020 Accepted instruction with exc_pend_MEM: exc_req = 1 for exactly that cycle, exc_pc = PC_MEM, exc_cause = exc_cause_MEM; no rf, CSR or fflags write; no retire.
REQ-021 trap_ret = trap_ret_MEM on acceptance without exc_pend; counts as retire.
REQ-022 fflags_wena = 1 and fflags_set = fpu_flags_MEM when accepted, no exc_pend and fpu_flags_MEM != 0.
REQ-023 rf_wena suppressed when rf_addr == 6'd0 (integer x0); FP f0 (6'd32) is writable.
REQ-024 flush_in in CSR_RD: abort with no CSR write, no rf write, no retire; flush_in in CSR_WR: the write completes this cycle, then IDLE.
REQ-025 exc_taken_csr high: no new transfer accepted that cycle.
REQ-026 All outputs not asserted per REQ-015..REQ-022 are 0.

Reset
REQ-027 reset = 0 at rising edge: state IDLE, old_q 0, latched fields 0, instret 0.
REQ-028 During reset all write enables, exc_req, trap_ret and ready_out are 0; a CSR sequence in progress is abandoned without a write.

Configuration
REQ-029 Macro WB_INSTRET_EN: defined -> instret increments by 1 per retire, wraps 2^INSTRET_W-1 -> 0; undefined -> counter not instantiated, instret tied 0.

Verification
REQ-030 ALU op rd=5, data 0x1234, valid_in=1 -> same cycle rf_wena=1, rf_addr=5, rf_data=0x1234; instret 0 -> 1.
REQ-031 CSRRS csr 0x300, csr_rdata=0x8, wdata=0x3, rd=7 -> cycles IDLE/CSR_RD/CSR_WR; csr_wdata=0xB; rf_data=0x8 to x7; ready_out 0 for 2 cycles.
REQ-032 exc_pend=1, PC=0x100, cause=0x5 -> exc_req one cycle, exc_pc=0x100, exc_cause=0x5; rf_wena=0; instret unchanged.
REQ-033 rd=0 data 0xFFFF with rd_wena -> rf_wena=0; rd=32 -> rf_wena=1.
REQ-034 flush_in during CSR_RD -> csr_wena never 1, state IDLE next cycle; reset mid-CSR_WR -> no write, instret 0.
REQ-035 instret preloaded 2^64-1 via force, one retire -> 0 (WB_INSTRET_EN defined); undefined -> instret stays 0.
